// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: streaming peak detector for FFT magnitude frames.
// One bin arrives per valid beat. The strongest bin inside [LO_BIN, HI_BIN] with
// a magnitude at or above threshold wins, and its results are latched at frame end.
// A frame ends on in_last, or is force-closed when the beat count reaches MAX_BINS.
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   in_valid/in_bin/in_mag/in_last - magnitude beat stream (no backpressure)
//   threshold             - minimum qualifying magnitude, sampled per beat
//   hold_en               - 1: decaying peak hold, 0: hold_amp follows max_amp
//   max_bin/max_amp/max_freq/peak_found - results of the last completed frame
//   frame_done/frame_err  - one-cycle pulses when the results update
//   hold_amp              - peak-hold amplitude
module fft_peak_tracker #(
  parameter int unsigned BIN_W       = 11,
  parameter int unsigned MAG_W       = 10,
  parameter int unsigned FREQ_W      = 13,
  parameter int unsigned MAX_BINS    = 1024,
  parameter int unsigned LO_BIN      = 1,
  parameter int unsigned HI_BIN      = 511,
  parameter int unsigned FREQ_MULT   = 8,
  parameter int unsigned DECAY_SHIFT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BIN_W-1:0]  in_bin,
  input  logic [MAG_W-1:0]  in_mag,
  input  logic              in_last,
  input  logic [MAG_W-1:0]  threshold,
  input  logic              hold_en,
  output logic [BIN_W-1:0]  max_bin,
  output logic [MAG_W-1:0]  max_amp,
  output logic [FREQ_W-1:0] max_freq,
  output logic              peak_found,
  output logic              frame_done,
  output logic              frame_err,
  output logic [MAG_W-1:0]  hold_amp
);

  localparam int unsigned CNT_W  = $clog2(MAX_BINS) + 1;
  localparam int unsigned MULT_W = $clog2(FREQ_MULT + 1);
  localparam int unsigned PROD_W = BIN_W + MULT_W;
  // One spare bit so the saturation compare is valid whichever of PROD_W/FREQ_W is wider
  localparam int unsigned CMP_W  = ((PROD_W > FREQ_W) ? PROD_W : FREQ_W) + 1;
  localparam logic [CMP_W-1:0] FREQ_SAT = {{(CMP_W - FREQ_W){1'b0}}, {FREQ_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_CLOSE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_cand_vld;
  logic [BIN_W-1:0]  r_cand_bin;
  logic [MAG_W-1:0]  r_cand_amp;

  logic              w_in_band;
  logic              w_qual;
  logic              w_take;
  logic              w_win_vld;
  logic [BIN_W-1:0]  w_win_bin;
  logic [MAG_W-1:0]  w_win_amp;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_cnt_full;
  logic              w_close;
  logic              w_force;
  logic [CMP_W-1:0]  w_prod;
  logic [FREQ_W-1:0] w_freq;
  logic [MAG_W-1:0]  w_decay;
  logic [MAG_W-1:0]  w_hold_next;

  // Beat qualification, candidate update and frame-close detection
  always_comb begin
    w_in_band  = 1'b0;
    w_qual     = 1'b0;
    w_take     = 1'b0;
    w_win_vld  = r_cand_vld;
    w_win_bin  = r_cand_bin;
    w_win_amp  = r_cand_amp;
    w_cnt_inc  = r_cnt + CNT_W'(1);
    w_cnt_full = 1'b0;
    w_close    = 1'b0;
    w_force    = 1'b0;

    w_in_band  = (in_bin >= BIN_W'(LO_BIN)) && (in_bin <= BIN_W'(HI_BIN));
    w_qual     = in_valid && w_in_band && (in_mag >= threshold);
    // Strict compare: ties keep the earliest qualifying beat
    w_take     = w_qual && (!r_cand_vld || (in_mag > r_cand_amp));
    w_win_vld  = r_cand_vld || w_qual;
    if (w_take) begin
      w_win_bin = in_bin;
      w_win_amp = in_mag;
    end
    w_cnt_full = (w_cnt_inc == CNT_W'(MAX_BINS));
    w_close    = in_valid && (in_last || w_cnt_full);
    w_force    = in_valid && !in_last && w_cnt_full;
  end

  // Saturated frequency and peak-hold update for the frame being closed
  always_comb begin
    w_prod      = '0;
    w_freq      = '0;
    w_decay     = '0;
    w_hold_next = '0;

    w_prod  = CMP_W'(w_win_bin) * CMP_W'(FREQ_MULT);
    w_freq  = (w_prod > FREQ_SAT) ? {FREQ_W{1'b1}} : w_prod[FREQ_W-1:0];
    w_decay = hold_amp - (hold_amp >> DECAY_SHIFT);
    if (hold_en && (w_decay > w_win_amp)) begin
      w_hold_next = w_decay;
    end else begin
      w_hold_next = w_win_amp;
    end
  end

  // Frame sequencing: a beat in the CLOSE cycle opens the next frame
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE, S_CLOSE: begin
        if (w_close) begin
          w_state_next = S_CLOSE;
        end else if (in_valid) begin
          w_state_next = S_ACCUM;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (w_close) begin
          w_state_next = S_CLOSE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Accumulator, beat counter and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= '0;
      r_cand_vld <= 1'b0;
      r_cand_bin <= '0;
      r_cand_amp <= '0;
      max_bin    <= '0;
      max_amp    <= '0;
      max_freq   <= '0;
      peak_found <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      hold_amp   <= '0;
    end else begin
      frame_done <= w_close;
      frame_err  <= w_force;
      if (w_close) begin
        max_bin    <= w_win_bin;
        max_amp    <= w_win_amp;
        max_freq   <= w_freq;
        peak_found <= w_win_vld;
        hold_amp   <= w_hold_next;
        r_cnt      <= '0;
        r_cand_vld <= 1'b0;
        r_cand_bin <= '0;
        r_cand_amp <= '0;
      end else if (in_valid) begin
        r_cnt      <= w_cnt_inc;
        r_cand_vld <= w_win_vld;
        r_cand_bin <= w_win_bin;
        r_cand_amp <= w_win_amp;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Testbench for fft_peak_tracker: directed and random frames, reference model
// evaluated per completed frame, results checked by a decoupled monitor.
module tb_fft_peak_tracker;

  localparam int BIN_W       = 11;
  localparam int MAG_W       = 10;
  localparam int FREQ_W      = 13;
  localparam int MAX_BINS    = 1024;
  localparam int LO_BIN      = 1;
  localparam int HI_BIN      = 511;
  localparam int FREQ_MULT   = 20;
  localparam int DECAY_SHIFT = 3;
  localparam int FREQ_MAX    = (1 << FREQ_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [BIN_W-1:0]  in_bin;
  logic [MAG_W-1:0]  in_mag;
  logic              in_last;
  logic [MAG_W-1:0]  threshold;
  logic              hold_en;
  logic [BIN_W-1:0]  max_bin;
  logic [MAG_W-1:0]  max_amp;
  logic [FREQ_W-1:0] max_freq;
  logic              peak_found;
  logic              frame_done;
  logic              frame_err;
  logic [MAG_W-1:0]  hold_amp;

  always #5 clock = ~clock;

  fft_peak_tracker #(
    .BIN_W(BIN_W), .MAG_W(MAG_W), .FREQ_W(FREQ_W), .MAX_BINS(MAX_BINS),
    .LO_BIN(LO_BIN), .HI_BIN(HI_BIN), .FREQ_MULT(FREQ_MULT), .DECAY_SHIFT(DECAY_SHIFT)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_bin(in_bin),
    .in_mag(in_mag), .in_last(in_last), .threshold(threshold), .hold_en(hold_en),
    .max_bin(max_bin), .max_amp(max_amp), .max_freq(max_freq),
    .peak_found(peak_found), .frame_done(frame_done), .frame_err(frame_err),
    .hold_amp(hold_amp)
  );

  typedef struct { int bin; int mag; int thr; } beat_t;
  typedef struct { int bin; int amp; int freq; int found; int err; int hold; } res_t;

  beat_t frame_q[$];
  res_t  exp_q[$];
  res_t  last_res;
  int    m_hold;
  int    n_tests;
  int    n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan the buffered frame for the first strictly-largest qualifying bin
  task automatic model_close(input bit forced);
    res_t r;
    int   best;
    int   best_bin;
    int   decayed;
    best     = -1;
    best_bin = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i].bin >= LO_BIN && frame_q[i].bin <= HI_BIN &&
          frame_q[i].mag >= frame_q[i].thr && frame_q[i].mag > best) begin
        best     = frame_q[i].mag;
        best_bin = frame_q[i].bin;
      end
    end
    r.found = (best >= 0) ? 1 : 0;
    r.bin   = r.found ? best_bin : 0;
    r.amp   = r.found ? best : 0;
    r.freq  = (r.bin * FREQ_MULT > FREQ_MAX) ? FREQ_MAX : r.bin * FREQ_MULT;
    r.err   = forced ? 1 : 0;
    decayed = m_hold - m_hold / (1 << DECAY_SHIFT);
    r.hold  = (hold_en && decayed > r.amp) ? decayed : r.amp;
    m_hold  = r.hold;
    exp_q.push_back(r);
    frame_q.delete();
  endtask

  task automatic send(input int b, input int m, input bit last, input int thr);
    in_valid  = 1'b1;
    in_bin    = BIN_W'(b);
    in_mag    = MAG_W'(m);
    in_last   = last;
    threshold = MAG_W'(thr);
    frame_q.push_back('{b, m, thr});
    if (last || frame_q.size() == MAX_BINS) model_close(!last);
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bin"},   int'(max_bin),    0);
    check({tag, "_amp"},   int'(max_amp),    0);
    check({tag, "_freq"},  int'(max_freq),   0);
    check({tag, "_found"}, int'(peak_found), 0);
    check({tag, "_done"},  int'(frame_done), 0);
    check({tag, "_err"},   int'(frame_err),  0);
    check({tag, "_hold"},  int'(hold_amp),   0);
  endtask

  // Monitor: pop on frame_done, otherwise outputs must hold the last results
  initial begin
    res_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (frame_done) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame_done: got 1 expected 0 (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            check("done_bin",   int'(max_bin),    e.bin);
            check("done_amp",   int'(max_amp),    e.amp);
            check("done_freq",  int'(max_freq),   e.freq);
            check("done_found", int'(peak_found), e.found);
            check("done_err",   int'(frame_err),  e.err);
            check("done_hold",  int'(hold_amp),   e.hold);
            last_res = e;
          end
        end else begin
          check("idle_err",  int'(frame_err), 0);
          check("idle_bin",  int'(max_bin),   last_res.bin);
          check("idle_amp",  int'(max_amp),   last_res.amp);
          check("idle_freq", int'(max_freq),  last_res.freq);
          check("idle_hold", int'(hold_amp),  last_res.hold);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    int len;
    int thr;
    n_tests   = 0;
    n_fail    = 0;
    m_hold    = 0;
    last_res  = '{0, 0, 0, 0, 0, 0};
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_bin    = '0;
    in_mag    = '0;
    in_last   = 1'b0;
    threshold = '0;
    hold_en   = 1'b0;
    idle(3);
    check_zero("reset");
    reset = 1'b0;
    idle(2);

    // Full 1024-bin frame, single strong bin; in_last coincides with the count limit
    for (int i = 0; i < 1024; i++) send(i, (i == 37) ? 700 : 50, i == 1023, 100);
    idle(3);

    // DC and out-of-band bins ignored, tie keeps the earlier bin
    for (int i = 0; i < 700; i++) begin
      m = 10;
      if (i == 20 || i == 90) m = 500;
      if (i == 0) m = 1023;
      if (i == 600) m = 900;
      send(i, m, i == 699, 100);
    end
    idle(2);

    // Nothing above threshold
    for (int i = 0; i < 64; i++) send(i, 80, i == 63, 100);
    idle(2);

    // Peak at HI_BIN saturates frequency; peak at 300 does not; LO_BIN edge qualifies
    for (int i = 500; i <= 520; i++) send(i, (i == 511) ? 300 : 20, i == 520, 100);
    idle(1);
    for (int i = 290; i <= 310; i++) send(i, (i == 300) ? 300 : 20, i == 310, 100);
    idle(1);
    send(0, 1023, 1'b0, 100);
    send(1, 999, 1'b0, 100);
    send(512, 1023, 1'b1, 100);
    idle(2);

    // Forced close at MAX_BINS; beat in the CLOSE cycle opens the next frame
    for (int i = 0; i < 1030; i++) begin
      if (i == 1024)     send(7, 250, 1'b0, 100);
      else if (i == 400) send(400, 600, 1'b0, 100);
      else               send(i % 1024, 50, 1'b0, 100);
    end
    send(3, 10, 1'b1, 100);
    idle(2);

    // Decaying hold: 800 then a weak frame, then decay toward the floor
    hold_en = 1'b1;
    for (int i = 1; i <= 10; i++) send(i, (i == 5) ? 800 : 0, i == 10, 100);
    idle(1);
    for (int i = 1; i <= 10; i++) send(i, (i == 5) ? 100 : 0, i == 10, 50);
    idle(1);
    for (int f = 0; f < 40; f++) begin
      send(2, 0, 1'b0, 100);
      send(3, 0, 1'b1, 100);
    end
    idle(2);

    // Reset mid-frame discards the partial frame and clears everything
    send(50, 900, 1'b0, 100);
    send(51, 20, 1'b0, 100);
    reset    = 1'b1;
    frame_q.delete();
    m_hold   = 0;
    @(posedge clock); #1;
    check_zero("midreset");
    last_res = '{0, 0, 0, 0, 0, 0};
    reset    = 1'b0;
    for (int i = 40; i < 60; i++) send(i, (i == 45) ? 150 : 30, i == 59, 100);
    idle(2);

    // Random frames: random bins, magnitudes (some quantized for ties), thresholds, gaps
    for (int f = 0; f < 30; f++) begin
      len     = $urandom_range(1, 60);
      hold_en = 1'($urandom_range(0, 1));
      thr     = $urandom_range(0, 600);
      if (len == 1) idle(1);
      for (int i = 0; i < len; i++) begin
        if (i > 0 && $urandom_range(0, 7) == 0) idle(1);
        if ($urandom_range(0, 9) == 0) thr = $urandom_range(0, 600);
        if ($urandom_range(0, 1) == 0) m = $urandom_range(0, 7) * 128;
        else                           m = $urandom_range(0, 1023);
        send($urandom_range(0, 1023), m, i == len - 1, thr);
      end
      idle($urandom_range(0, 2));
    end

    idle(5);
    check("pending_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
